// File: rtl/zigbee_cordic_iter_ctrl.sv
// zigbee_cordic_iter_ctrl: iterative vectoring CORDIC, (I,Q) -> magnitude and phase
// Ports: clk, rst (async, active high); in_valid/in_ready/in_i/in_q sample input;
//        out_valid/out_ready/out_mag/out_phase result output; busy while rotating or holding a result.
module zigbee_cordic_iter_ctrl #(
    parameter int XY_SIZE  = 12,
    parameter int W_SIZE   = 16,
    parameter int NUM_ITER = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XY_SIZE-1:0]   in_i,
    input  logic [XY_SIZE-1:0]   in_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XY_SIZE+1:0]   out_mag,
    output logic [W_SIZE-1:0]    out_phase,
    output logic                 busy
);
    localparam int XW = XY_SIZE + 2;
    localparam int CW = $clog2(W_SIZE);
    localparam int TN = 1 << CW;
    localparam logic signed [W_SIZE-1:0] QTR = W_SIZE'(1 << (W_SIZE - 2));

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic signed [XW-1:0]    x, y, si, sq, xs, ys;
    logic signed [W_SIZE-1:0] w;
    logic [W_SIZE-1:0]       atan_tab [TN];
    logic                    pos;

    // arctangent table rounded at elaboration; entries past NUM_ITER are never selected
    for (genvar g = 0; g < TN; g++) begin : g_atan
        localparam real A = $atan(2.0 ** (-g)) * (2.0 ** (W_SIZE - 1)) / 3.14159265358979;
        assign atan_tab[g] = W_SIZE'($rtoi(A + 0.5));
    end

    assign si  = {{2{in_i[XY_SIZE-1]}}, in_i};
    assign sq  = {{2{in_q[XY_SIZE-1]}}, in_q};
    assign xs  = x >>> cnt;
    assign ys  = y >>> cnt;
    assign pos = ~y[XW-1];
    assign out_mag   = x;
    assign out_phase = w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            x         <= '0;
            y         <= '0;
            w         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // fold left half-plane into the right half-plane by a +/-90 degree turn
                    x        <= ~si[XW-1] ? si : (~sq[XW-1] ? sq : -sq);
                    y        <= ~si[XW-1] ? sq : (~sq[XW-1] ? -si : si);
                    w        <= ~si[XW-1] ? '0 : (~sq[XW-1] ? QTR : -QTR);
                    cnt      <= '0;
                    state    <= ROT;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                ROT: begin
                    x   <= pos ? x + ys : x - ys;
                    y   <= pos ? y - xs : y + xs;
                    w   <= pos ? w + atan_tab[cnt] : w - atan_tab[cnt];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NUM_ITER - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zigbee_cordic_iter_ctrl.sv
// tb_zigbee_cordic_iter_ctrl: directed self-checking bench for the CORDIC iteration controller
module tb_zigbee_cordic_iter_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_i = '0;
    logic [11:0] in_q = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [13:0] out_mag;
    logic [15:0] out_phase;
    logic        busy;

    int total = 0;
    int passed = 0;
    int mag, ph, lat;

    zigbee_cordic_iter_ctrl #(.XY_SIZE(12), .W_SIZE(16), .NUM_ITER(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_i(in_i), .in_q(in_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_mag(out_mag), .out_phase(out_phase), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic near(input string tag, input int obs, input int exp, input int tol);
        total++;
        assert (((obs - exp <= tol) && (exp - obs <= tol)) === 1'b1) passed++;
        else $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    endtask

    task automatic start(input int i, input int q);
        @(negedge clk);
        in_i = 12'(i);
        in_q = 12'(q);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) chk("valid_timeout", 0, 1);
        mag = int'(out_mag);
        ph  = int'($signed(out_phase));
    endtask

    task automatic run(input int i, input int q);
        start(i, q);
        wait_valid();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, bad, v, m0, p0, stable;
        int acc [4];
        logic signed [15:0] pd;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mag", int'(out_mag), 0);
        chk("rst_phase", int'(out_phase), 0);

        run(1000, 0);
        chk("lat_1000_0", lat, 13);
        near("mag_1000_0", mag, 1647, 3);
        near("ph_1000_0", ph, 0, 8);
        chk("ready_after_xfer", int'(in_ready), 1);
        chk("valid_after_xfer", int'(out_valid), 0);

        run(0, 1000);
        near("ph_0_1000", ph, 16384, 8);

        run(-1000, -1000);
        near("ph_m1000_m1000", ph, -24576, 8);
        near("mag_m1000_m1000", mag, 2329, 4);

        run(-1000, 0);
        pd = 16'(ph) - 16'sh8000;
        near("ph_wrap_m1000_0", int'(pd), 0, 8);

        run(0, 0);
        near("mag_zero", mag, 0, 2);

        // back-to-back: producer holds in_valid high
        @(negedge clk);
        in_i = 12'd1000;
        in_q = 12'd0;
        in_valid = 1'b1;
        n = 0;
        bad = 0;
        for (int c = 0; c < 45; c++) begin
            if (in_ready) begin
                if (n < 4) acc[n] = c;
                n++;
            end
            if (in_ready === busy) bad++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_accepts", n, 4);
        chk("b2b_gap0", acc[1] - acc[0], 14);
        chk("b2b_gap1", acc[2] - acc[1], 14);
        chk("b2b_ready_vs_busy", bad, 0);
        for (int c = 0; c < 40 && !in_ready; c++) @(negedge clk);
        chk("b2b_drain", int'(in_ready), 1);

        // consumer stall
        @(negedge clk);
        out_ready = 1'b0;
        start(1000, 0);
        wait_valid();
        m0 = mag;
        p0 = ph;
        near("stall_mag", m0, 1647, 3);
        stable = 1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!(out_valid === 1'b1 && int'(out_mag) == m0 && int'($signed(out_phase)) == p0
                  && in_ready === 1'b0 && busy === 1'b1)) stable = 0;
        end
        chk("stall_stable", stable, 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_valid", int'(out_valid), 0);
        chk("stall_release_ready", int'(in_ready), 1);
        chk("stall_release_busy", int'(busy), 0);

        // reset during the fifth rotation cycle
        start(-1000, -1000);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_mag", int'(out_mag), 0);
        chk("midrst_phase", int'(out_phase), 0);
        @(negedge clk);
        rst = 1'b0;
        v = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) v++;
        end
        chk("midrst_no_valid", v, 0);
        run(-1000, -1000);
        near("post_rst_ph", ph, -24576, 8);
        near("post_rst_mag", mag, 2329, 4);

        run(-2048, -2048);
        near("ph_full_neg", ph, -24576, 8);
        near("mag_full_neg", mag, 4770, 6);

        run(2047, -2048);
        near("ph_q4_full", ph, -8192, 8);
        near("mag_q4_full", mag, 4770, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
